rf_wb_sched: RTL and testbench
==============================

RF_WB_SCHED -- requirements
Module: rf_wb_sched

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count; register address width = 5.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports exu_valid in 1 / exu_ready out 1 / exu_rd in 5 / exu_wdata in XLEN  ALU writeback request, requester 0.
REQ-006 SHALL have ports lsu_valid in 1 / lsu_ready out 1 / lsu_rd in 5 / lsu_wdata in XLEN  load writeback request, requester 1.
REQ-007 SHALL have ports rf_wen out 1 / rf_waddr out 5 / rf_wdata out XLEN  to the register-file write port.
REQ-008 SHALL have ports iss_valid in 1 / iss_ready out 1 / iss_rd in 5  issue of an instruction that reserves a destination register.
REQ-009 SHALL have ports rs1 in 5 / rs2 in 5 / raw_stall out 1  source-operand hazard query.
REQ-010 SHALL have ports flush in 1 / pend_cnt out 6 / idle out 1  scoreboard clear, outstanding-write count, no-pending flag.

Function
REQ-011 SHALL keep busy[NREG-1:1]; x0 is never busy.
REQ-012 SHALL grant at most one requester per cycle; handshake = valid && ready; grant is combinational, with no added latency to rf_wen.
REQ-013 SHALL arbitrate round-robin: with both valid, the requester not granted last conflict wins; a 1-bit pointer updates only on a two-valid conflict.
REQ-014 SHALL hold the ready of a non-granted requester low; a requester that is alone valid is granted immediately.
REQ-015 SHALL drive rf_wen = granted && rd != 0; rf_waddr/rf_wdata = granted requester's rd/wdata; x0 writes complete handshake with rf_wen = 0.
REQ-016 SHALL clear busy[rd] at the clock edge following the granted write, and decrement pend_cnt if rd != 0.
REQ-017 SHALL drive iss_ready = !flush && (iss_rd == 0 || !busy[iss_rd]) (WAW stall).
REQ-018 SHALL set busy[iss_rd] and increment pend_cnt on an accepted issue with iss_rd != 0.
REQ-019 SHALL, on simultaneous issue-set and write-clear of different registers, apply both; pend_cnt net change 0.
REQ-020 SHALL drive raw_stall = (rs1 != 0 && busy[rs1] && !(rf_wen && rf_waddr == rs1)) || same for rs2 (same-cycle write resolves hazard via regfile write-through timing at next edge).
REQ-021 SHALL, on flush, clear all busy bits and pend_cnt to 0 at the next edge, overriding same-cycle set/clear; writeback handshakes still complete and still drive rf_wen.
REQ-022 SHALL drive idle = (pend_cnt == 0).
REQ-023 SHALL never allow pend_cnt to exceed 31 or underflow; a granted write to a non-busy register (post-flush) SHALL NOT decrement.

Reset
REQ-024 SHALL, while rst_n low, force busy = 0, pend_cnt = 0, idle = 1, round-robin pointer = EXU priority.
REQ-025 SHALL, while in reset, drive exu_ready = lsu_ready = iss_ready = 0, rf_wen = 0, raw_stall = 0.
REQ-026 SHALL, on reset mid-operation, discard all pending reservations; the first post-reset edge starts from the reset state.

Structure
REQ-027 SHALL take XLEN, register-address width and NREG from the shared defines/package used by the register file.
REQ-028 SHALL place requester-index enum (REQ_EXU = 0, REQ_LSU = 1) in the shared package.
REQ-029 SHALL instantiate one sub-module, rf_scoreboard (busy bits, pend_cnt, hazard compare); the arbiter stays in rf_wb_sched.

Verification
REQ-030 SHALL test: issue rd=5, next cycle rs1=5 -> raw_stall=1; exu write rd=5 data 0xDEADBEEF -> rf_wen=1, waddr=5, raw_stall=0 that cycle, busy[5]=0 next.
REQ-031 SHALL test: exu and lsu valid for 4 cycles (rd 3/4, pre-issued) -> grants EXU,LSU,EXU,LSU; losing ready=0.
REQ-032 SHALL test: issue rd=7 while busy[7] -> iss_ready=0, pend_cnt unchanged; after write to 7, issue accepted.
REQ-033 SHALL test: lsu write rd=0 -> lsu_ready=1, rf_wen=0, pend_cnt unchanged.
REQ-034 SHALL test: 3 reservations, flush with concurrent issue rd=9 -> pend_cnt=0, idle=1, busy[9]=0.
REQ-035 SHALL test: rst_n low mid-transfer with pend_cnt=2 -> all readies 0 immediately, pend_cnt=0, EXU wins first conflict after release.

Source files
------------

// File: rtl/rf_wb_sched_pkg.sv
// Shared register-file parameters and writeback requester indices.
package rf_wb_sched_pkg;
    localparam int RF_XLEN = 32;
    localparam int RF_NREG = 32;
    localparam int RF_AW   = 5;
    localparam int RF_CNTW = 6;

    typedef enum logic {
        REQ_EXU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;
endpackage

// File: rtl/rf_wb_sched_scoreboard.sv
// Destination-register scoreboard: busy bits, outstanding count, hazard compare.
module rf_scoreboard
    import rf_wb_sched_pkg::*;
#(
    parameter int NREG = RF_NREG
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               iss_valid,
    input  logic [RF_AW-1:0]   iss_rd,
    output logic               iss_ready,
    input  logic               clr_en,
    input  logic [RF_AW-1:0]   clr_rd,
    input  logic               wen,
    input  logic [RF_AW-1:0]   waddr,
    input  logic [RF_AW-1:0]   rs1,
    input  logic [RF_AW-1:0]   rs2,
    output logic               raw_stall,
    output logic [RF_CNTW-1:0] pend_cnt,
    output logic               idle
);
    localparam logic [RF_CNTW-1:0] PEND_MAX = RF_CNTW'(NREG - 1);
    localparam logic [RF_CNTW-1:0] ONE = RF_CNTW'(1);

    logic [NREG-1:0]    busy_q, busy_d;
    logic [RF_CNTW-1:0] pend_q, pend_d;
    logic               set_hit, clr_hit, haz1, haz2;

    assign iss_ready = rst_n && !flush && (iss_rd == '0 || !busy_q[iss_rd]);
    assign set_hit   = iss_valid && iss_ready && iss_rd != '0;
    // A write to a register that is not reserved (e.g. after flush) is a no-op.
    assign clr_hit   = clr_en && clr_rd != '0 && busy_q[clr_rd];

    assign haz1 = rs1 != '0 && busy_q[rs1] && !(wen && waddr == rs1);
    assign haz2 = rs2 != '0 && busy_q[rs2] && !(wen && waddr == rs2);

    assign raw_stall = rst_n && (haz1 || haz2);
    assign pend_cnt  = pend_q;
    assign idle      = pend_q == '0;

    always_comb begin
        busy_d = busy_q;
        pend_d = pend_q;
        if (clr_hit) busy_d[clr_rd] = 1'b0;
        if (set_hit) busy_d[iss_rd] = 1'b1;
        if (set_hit && !clr_hit && pend_q != PEND_MAX) begin
            pend_d = pend_q + ONE;
        end else if (clr_hit && !set_hit && pend_q != '0) begin
            pend_d = pend_q - ONE;
        end
        if (flush) begin
            busy_d = '0;
            pend_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: rtl/rf_wb_sched.sv
// Register-file writeback scheduler: round-robin EXU/LSU write arbiter
// plus a scoreboard of reserved destination registers.
module rf_wb_sched
    import rf_wb_sched_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int NREG = RF_NREG
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               exu_valid,
    output logic               exu_ready,
    input  logic [RF_AW-1:0]   exu_rd,
    input  logic [XLEN-1:0]    exu_wdata,
    input  logic               lsu_valid,
    output logic               lsu_ready,
    input  logic [RF_AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0]    lsu_wdata,
    output logic               rf_wen,
    output logic [RF_AW-1:0]   rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    input  logic               iss_valid,
    output logic               iss_ready,
    input  logic [RF_AW-1:0]   iss_rd,
    input  logic [RF_AW-1:0]   rs1,
    input  logic [RF_AW-1:0]   rs2,
    output logic               raw_stall,
    input  logic               flush,
    output logic [RF_CNTW-1:0] pend_cnt,
    output logic               idle
);
    req_e prio_q, prio_d;
    logic exu_gnt, lsu_gnt, gnt, conflict;

    assign conflict = exu_valid && lsu_valid;
    assign exu_gnt  = rst_n && exu_valid && (!lsu_valid || prio_q == REQ_EXU);
    assign lsu_gnt  = rst_n && lsu_valid && !exu_gnt;
    assign gnt      = exu_gnt || lsu_gnt;

    assign exu_ready = exu_gnt;
    assign lsu_ready = lsu_gnt;
    assign rf_waddr  = lsu_gnt ? lsu_rd : exu_rd;
    assign rf_wdata  = lsu_gnt ? lsu_wdata : exu_wdata;
    assign rf_wen    = gnt && rf_waddr != '0;

    // Priority only rotates when both requesters actually collide.
    always_comb begin
        prio_d = prio_q;
        if (conflict) prio_d = exu_gnt ? REQ_LSU : REQ_EXU;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_q <= REQ_EXU;
        else        prio_q <= prio_d;
    end

    rf_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .clr_en    (gnt),
        .clr_rd    (rf_waddr),
        .wen       (rf_wen),
        .waddr     (rf_waddr),
        .rs1       (rs1),
        .rs2       (rs2),
        .raw_stall (raw_stall),
        .pend_cnt  (pend_cnt),
        .idle      (idle)
    );
endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: directed scenarios plus random traffic against a
// set-of-reserved-registers reference model.
module tb_rf_wb_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
    logic [4:0]  exu_rd, lsu_rd, rf_waddr, iss_rd, rs1, rs2;
    logic [31:0] exu_wdata, lsu_wdata, rf_wdata;
    logic        rf_wen, iss_valid, iss_ready, raw_stall, flush, idle;
    logic [5:0]  pend_cnt;

    int n_chk = 0;
    int n_err = 0;

    bit busy_m [32];
    int pri_m = 0;
    int win;
    bit e_wen, e_iss, e_raw;
    logic [4:0]  e_wrd;
    logic [31:0] e_wdata;

    always #5 clk = ~clk;

    rf_wb_sched dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready),
        .exu_rd(exu_rd), .exu_wdata(exu_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .rs1(rs1), .rs2(rs2), .raw_stall(raw_stall),
        .flush(flush), .pend_cnt(pend_cnt), .idle(idle)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pend_m();
        int c = 0;
        for (int i = 1; i < 32; i++) c += int'(busy_m[i]);
        return rst_n ? c : 0;
    endfunction

    function automatic bit hz(input logic [4:0] r);
        return r != 0 && busy_m[r] && !(e_wen && e_wrd == r);
    endfunction

    task automatic model_eval();
        if (!rst_n) win = -1;
        else if (exu_valid && lsu_valid) win = pri_m;
        else if (exu_valid) win = 0;
        else if (lsu_valid) win = 1;
        else win = -1;
        e_wrd   = (win == 1) ? lsu_rd : exu_rd;
        e_wdata = (win == 1) ? lsu_wdata : exu_wdata;
        e_wen   = win >= 0 && e_wrd != 0;
        e_iss   = rst_n && !flush && (iss_rd == 0 || !busy_m[iss_rd]);
        e_raw   = rst_n && (hz(rs1) || hz(rs2));
    endtask

    task automatic model_check();
        int p;
        model_eval();
        p = pend_m();
        chk("exu_ready", exu_ready, win == 0);
        chk("lsu_ready", lsu_ready, win == 1);
        chk("rf_wen", rf_wen, e_wen);
        if (e_wen) begin
            chk("rf_waddr", rf_waddr, e_wrd);
            chk("rf_wdata", rf_wdata, e_wdata);
        end
        chk("iss_ready", iss_ready, e_iss);
        chk("raw_stall", raw_stall, e_raw);
        chk("pend_cnt", pend_cnt, p);
        chk("idle", idle, p == 0);
    endtask

    task automatic model_update();
        model_eval();
        if (!rst_n) begin
            foreach (busy_m[i]) busy_m[i] = 1'b0;
            pri_m = 0;
        end else begin
            if (exu_valid && lsu_valid) pri_m = 1 - win;
            if (flush) begin
                foreach (busy_m[i]) busy_m[i] = 1'b0;
            end else begin
                if (win >= 0 && e_wrd != 0) busy_m[e_wrd] = 1'b0;
                if (iss_valid && e_iss && iss_rd != 0) busy_m[iss_rd] = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clr_in();
        exu_valid = 0; lsu_valid = 0; iss_valid = 0; flush = 0;
        exu_rd = 0; lsu_rd = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
        exu_wdata = 0; lsu_wdata = 0;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 0;
        cycle();
        cycle();
        rst_n = 1;
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid = 1; iss_rd = rd;
        cycle();
        iss_valid = 0;
    endtask

    initial begin
        clr_in();
        @(posedge clk);
        #1;
        do_reset();
        #1;
        chk("rst_pend", pend_cnt, 0);
        chk("rst_idle", idle, 1);

        // RAW hazard on rd=5, resolved by a same-cycle writeback
        issue(5'd5);
        rs1 = 5;
        #1 chk("t30_raw_pre", raw_stall, 1);
        cycle();
        exu_valid = 1; exu_rd = 5; exu_wdata = 32'hDEADBEEF;
        #1;
        chk("t30_wen", rf_wen, 1);
        chk("t30_waddr", rf_waddr, 5);
        chk("t30_wdata", rf_wdata, 32'hDEADBEEF);
        chk("t30_raw_wr", raw_stall, 0);
        cycle();
        exu_valid = 0;
        #1 chk("t30_raw_post", raw_stall, 0);
        cycle();

        // Round-robin alternation under sustained conflict
        do_reset();
        issue(5'd3);
        issue(5'd4);
        exu_valid = 1; exu_rd = 3; exu_wdata = 32'h33;
        lsu_valid = 1; lsu_rd = 4; lsu_wdata = 32'h44;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t31_exu", exu_ready, (k % 2) == 0);
            chk("t31_lsu", lsu_ready, (k % 2) == 1);
            cycle();
        end
        clr_in();

        // WAW stall on rd=7
        do_reset();
        issue(5'd7);
        iss_valid = 1; iss_rd = 7;
        #1;
        chk("t32_iss_stall", iss_ready, 0);
        chk("t32_pend", pend_cnt, 1);
        cycle();
        iss_valid = 0;
        #1 chk("t32_pend_hold", pend_cnt, 1);
        exu_valid = 1; exu_rd = 7; exu_wdata = 32'h77;
        cycle();
        exu_valid = 0;
        iss_valid = 1; iss_rd = 7;
        #1 chk("t32_iss_ok", iss_ready, 1);
        cycle();
        iss_valid = 0;
        #1 chk("t32_pend_after", pend_cnt, 1);

        // Writeback to x0
        lsu_valid = 1; lsu_rd = 0; lsu_wdata = 32'h1234;
        #1;
        chk("t33_lsu_ready", lsu_ready, 1);
        chk("t33_wen", rf_wen, 0);
        cycle();
        lsu_valid = 0;
        #1 chk("t33_pend", pend_cnt, 1);

        // Flush overriding a concurrent issue
        do_reset();
        issue(5'd1);
        issue(5'd2);
        issue(5'd3);
        #1 chk("t34_pend3", pend_cnt, 3);
        flush = 1; iss_valid = 1; iss_rd = 9;
        cycle();
        flush = 0; iss_valid = 0; rs1 = 9; rs2 = 1;
        #1;
        chk("t34_pend", pend_cnt, 0);
        chk("t34_idle", idle, 1);
        chk("t34_busy9", raw_stall, 0);
        cycle();

        // Asynchronous reset in the middle of traffic
        do_reset();
        issue(5'd10);
        issue(5'd11);
        exu_valid = 1; exu_rd = 10; iss_valid = 1; iss_rd = 12;
        #1;
        chk("t35_pend2", pend_cnt, 2);
        chk("t35_exu_pre", exu_ready, 1);
        rst_n = 0;
        #1;
        chk("t35_exu", exu_ready, 0);
        chk("t35_lsu", lsu_ready, 0);
        chk("t35_iss", iss_ready, 0);
        chk("t35_wen", rf_wen, 0);
        chk("t35_pend", pend_cnt, 0);
        chk("t35_idle", idle, 1);
        cycle();
        cycle();
        rst_n = 1;
        iss_valid = 0;
        exu_valid = 1; exu_rd = 10; lsu_valid = 1; lsu_rd = 11;
        #1;
        chk("t35_first_exu", exu_ready, 1);
        chk("t35_first_lsu", lsu_ready, 0);
        cycle();
        clr_in();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom % 80) != 0;
            flush     = ($urandom % 25) == 0;
            exu_valid = $urandom % 2;
            lsu_valid = $urandom % 2;
            exu_rd    = 5'($urandom_range(0, 9));
            lsu_rd    = 5'($urandom_range(0, 9));
            exu_wdata = $urandom;
            lsu_wdata = $urandom;
            iss_valid = ($urandom % 3) != 0;
            iss_rd    = (i < 300) ? 5'($urandom_range(0, 9))
                                  : 5'($urandom_range(0, 31));
            rs1       = 5'($urandom_range(0, 9));
            rs2       = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
